// File: rtl/execute_issue_if.sv
// Handshake bundle between decode, the execute issue controller and the memory stage.
interface execute_issue_if #(
    parameter int unsigned TAG_W = 5
);
    logic             id_valid;
    logic             id_ready;
    logic [1:0]       id_op_class;
    logic [TAG_W-1:0] id_tag;
    logic             ex_valid;
    logic             ex_ready;
    logic [TAG_W-1:0] ex_tag;

    modport master (
        output id_valid, id_op_class, id_tag, ex_ready,
        input  id_ready, ex_valid, ex_tag
    );

    modport slave (
        input  id_valid, id_op_class, id_tag, ex_ready,
        output id_ready, ex_valid, ex_tag
    );
endinterface

// File: rtl/execute_issue_controller.sv
// Execute-stage sequencer: issues ALU/MUL/DIV work, holds the result slot until
// the memory stage takes it, and counts back-pressure cycles.
module execute_issue_controller #(
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned STALL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    execute_issue_if.slave     ifc,
    input  logic               flush,
    output logic               alu_en,
    output logic               mul_start,
    output logic               div_start,
    input  logic               div_done,
    output logic               unit_kill,
    output logic               execute_done,
    output logic               busy,
    output logic [STALL_W-1:0] stall_count
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        ALU_EX,
        MUL_WAIT,
        DIV_WAIT,
        HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [STALL_W-1:0] stall_q;
    logic               id_ready;
    logic               accept;
    logic               ex_valid;

    // State, latency counter and result tag registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
        end
    end

    // Saturating count of cycles the held result is back-pressured
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (state_q == HOLD && !ifc.ex_ready && stall_q != '1) begin
            stall_q <= stall_q + STALL_W'(1);
        end
    end

    // Next-state and handshake/strobe decode; reset gates the combinational strobes
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tag_d        = tag_q;
        alu_en       = 1'b0;
        mul_start    = 1'b0;
        div_start    = 1'b0;
        ex_valid     = (state_q == HOLD);
        id_ready     = reset && !flush &&
                       (state_q == IDLE || (state_q == HOLD && ifc.ex_ready));
        accept       = ifc.id_valid && id_ready;
        execute_done = reset && ex_valid && ifc.ex_ready && !flush;
        unit_kill    = reset && flush && (state_q == MUL_WAIT || state_q == DIV_WAIT);

        unique case (state_q)
            ALU_EX:   state_d = HOLD;
            MUL_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DIV_WAIT: begin
                if (div_done) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (ifc.ex_ready) begin
                    state_d = IDLE;
                end
            end
            default:  state_d = IDLE;
        endcase

        // A new accept overrides the HOLD->IDLE exit for back-to-back issue
        if (accept) begin
            tag_d = ifc.id_tag;
            unique case (ifc.id_op_class)
                2'b01: begin
                    mul_start = 1'b1;
                    cnt_d     = CNT_W'(MUL_LAT - 1);
                    state_d   = MUL_WAIT;
                end
                2'b10: begin
                    div_start = 1'b1;
                    state_d   = DIV_WAIT;
                end
                default: begin
                    alu_en  = 1'b1;
                    state_d = ALU_EX;
                end
            endcase
        end

        if (flush) begin
            state_d = IDLE;
        end
    end

    assign ifc.id_ready = id_ready;
    assign ifc.ex_valid = ex_valid;
    assign ifc.ex_tag   = tag_q;
    assign busy         = (state_q != IDLE);
    assign stall_count  = stall_q;
endmodule

// File: tb/tb_execute_issue_controller.sv
// Directed bench for execute_issue_controller with hand-derived cycle expectations.
module tb_execute_issue_controller;
    localparam int unsigned MUL_LAT = 3;
    localparam int unsigned TAG_W   = 5;
    localparam int unsigned STALL_W = 4;

    logic               clk;
    logic               reset;
    logic               flush;
    logic               alu_en;
    logic               mul_start;
    logic               div_start;
    logic               div_done;
    logic               unit_kill;
    logic               execute_done;
    logic               busy;
    logic [STALL_W-1:0] stall_count;

    int checks   = 0;
    int failures = 0;

    execute_issue_if #(.TAG_W(TAG_W)) ifc ();

    execute_issue_controller #(
        .MUL_LAT(MUL_LAT),
        .TAG_W  (TAG_W),
        .STALL_W(STALL_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ifc         (ifc.slave),
        .flush       (flush),
        .alu_en      (alu_en),
        .mul_start   (mul_start),
        .div_start   (div_start),
        .div_done    (div_done),
        .unit_kill   (unit_kill),
        .execute_done(execute_done),
        .busy        (busy),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then driven for that cycle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [TAG_W-1:0] tag);
        ifc.id_valid    = 1'b1;
        ifc.id_op_class = op;
        ifc.id_tag      = tag;
    endtask

    initial begin
        reset           = 1'b0;
        flush           = 1'b0;
        div_done        = 1'b0;
        ifc.ex_ready    = 1'b0;
        issue(2'b00, 5'd3);
        #3;
        check("rst_id_ready",  32'(ifc.id_ready), 32'd0);
        check("rst_alu_en",    32'(alu_en),       32'd0);
        check("rst_ex_valid",  32'(ifc.ex_valid), 32'd0);
        check("rst_ex_tag",    32'(ifc.ex_tag),   32'd0);
        check("rst_busy",      32'(busy),         32'd0);
        check("rst_stall",     32'(stall_count),  32'd0);
        ifc.id_valid = 1'b0;
        step();
        reset = 1'b1;

        // ALU: accept c0, result c2, idle c3
        step(); issue(2'b00, 5'd5); ifc.ex_ready = 1'b1; #1;
        check("alu_id_ready",  32'(ifc.id_ready), 32'd1);
        check("alu_en_c0",     32'(alu_en),       32'd1);
        check("alu_mul_c0",    32'(mul_start),    32'd0);
        step(); ifc.id_valid = 1'b0; #1;
        check("alu_busy_c1",   32'(busy),         32'd1);
        check("alu_exv_c1",    32'(ifc.ex_valid), 32'd0);
        check("alu_en_c1",     32'(alu_en),       32'd0);
        step(); #1;
        check("alu_exv_c2",    32'(ifc.ex_valid), 32'd1);
        check("alu_done_c2",   32'(execute_done), 32'd1);
        check("alu_tag_c2",    32'(ifc.ex_tag),   32'd5);
        step(); #1;
        check("alu_busy_c3",   32'(busy),         32'd0);

        // MUL: accept c0, result c3
        step(); issue(2'b01, 5'd9); #1;
        check("mul_start_c0",  32'(mul_start),    32'd1);
        check("mul_alu_c0",    32'(alu_en),       32'd0);
        step(); #1;
        check("mul_rdy_c1",    32'(ifc.id_ready), 32'd0);
        check("mul_start_c1",  32'(mul_start),    32'd0);
        step(); #1;
        check("mul_rdy_c2",    32'(ifc.id_ready), 32'd0);
        check("mul_exv_c2",    32'(ifc.ex_valid), 32'd0);
        ifc.id_valid = 1'b0;
        step(); #1;
        check("mul_exv_c3",    32'(ifc.ex_valid), 32'd1);
        check("mul_tag_c3",    32'(ifc.ex_tag),   32'd9);
        check("mul_done_c3",   32'(execute_done), 32'd1);
        step(); #1;
        check("mul_busy_c4",   32'(busy),         32'd0);

        // DIV: accept c0, div_done c7, result c8, four stalled cycles c8..c11
        step(); issue(2'b10, 5'd3); #1;
        check("div_start_c0",  32'(div_start),    32'd1);
        step(); ifc.id_valid = 1'b0;
        for (int c = 2; c <= 6; c++) step();
        #1;
        check("div_exv_c6",    32'(ifc.ex_valid), 32'd0);
        step(); div_done = 1'b1; ifc.ex_ready = 1'b0; #1;
        check("div_exv_c7",    32'(ifc.ex_valid), 32'd0);
        step(); div_done = 1'b0; #1;
        check("div_exv_c8",    32'(ifc.ex_valid), 32'd1);
        check("div_done_c8",   32'(execute_done), 32'd0);
        for (int c = 9; c <= 11; c++) step();
        #1;
        check("div_tag_c11",   32'(ifc.ex_tag),   32'd3);
        step(); ifc.ex_ready = 1'b1; #1;
        check("div_stall_c12", 32'(stall_count),  32'd4);
        check("div_tag_c12",   32'(ifc.ex_tag),   32'd3);
        check("div_done_c12",  32'(execute_done), 32'd1);
        step(); #1;
        check("div_busy_c13",  32'(busy),         32'd0);

        // Back-to-back: handoff and new ALU accept in the same HOLD cycle
        step(); issue(2'b00, 5'd7);
        step(); ifc.id_valid = 1'b0;
        step(); issue(2'b00, 5'd12); #1;
        check("b2b_done",      32'(execute_done), 32'd1);
        check("b2b_alu_en",    32'(alu_en),       32'd1);
        check("b2b_old_tag",   32'(ifc.ex_tag),   32'd7);
        step(); ifc.id_valid = 1'b0; #1;
        check("b2b_busy_gap",  32'(busy),         32'd1);
        check("b2b_exv_gap",   32'(ifc.ex_valid), 32'd0);
        step(); #1;
        check("b2b_exv",       32'(ifc.ex_valid), 32'd1);
        check("b2b_new_tag",   32'(ifc.ex_tag),   32'd12);
        step();

        // Flush in DIV_WAIT at c2, stray div_done afterwards
        step(); issue(2'b10, 5'd4);
        step(); ifc.id_valid = 1'b0;
        step(); flush = 1'b1; #1;
        check("fl_kill_c2",    32'(unit_kill),    32'd1);
        check("fl_rdy_c2",     32'(ifc.id_ready), 32'd0);
        step(); flush = 1'b0; #1;
        check("fl_busy_c3",    32'(busy),         32'd0);
        check("fl_kill_c3",    32'(unit_kill),    32'd0);
        step(); div_done = 1'b1;
        step(); div_done = 1'b0; #1;
        check("fl_stray_busy", 32'(busy),         32'd0);
        check("fl_stray_exv",  32'(ifc.ex_valid), 32'd0);

        // Flush with a valid request: no accept, no start
        step(); flush = 1'b1; issue(2'b01, 5'd8); #1;
        check("flv_rdy",       32'(ifc.id_ready), 32'd0);
        check("flv_mul",       32'(mul_start),    32'd0);
        check("flv_alu",       32'(alu_en),       32'd0);
        check("flv_kill_idle", 32'(unit_kill),    32'd0);
        step(); flush = 1'b0; ifc.id_valid = 1'b0; #1;
        check("flv_busy",      32'(busy),         32'd0);

        // Flush in HOLD suppresses execute_done and drops ex_valid
        step(); issue(2'b00, 5'd2);
        step(); ifc.id_valid = 1'b0;
        step(); flush = 1'b1; #1;
        check("flh_exv",       32'(ifc.ex_valid), 32'd1);
        check("flh_done",      32'(execute_done), 32'd0);
        check("flh_kill",      32'(unit_kill),    32'd0);
        step(); flush = 1'b0; #1;
        check("flh_exv_next",  32'(ifc.ex_valid), 32'd0);

        // Saturation: 4 prior stalls + 20 more clamps at 15
        step(); issue(2'b00, 5'd1); ifc.ex_ready = 1'b0;
        step(); ifc.id_valid = 1'b0;
        for (int c = 0; c < 20; c++) step();
        #1;
        check("sat_stall",     32'(stall_count),  32'd15);
        check("sat_exv",       32'(ifc.ex_valid), 32'd1);
        check("sat_tag",       32'(ifc.ex_tag),   32'd1);
        step(); ifc.ex_ready = 1'b1; #1;
        check("sat_done",      32'(execute_done), 32'd1);
        step();

        // Reset asserted mid-MUL clears everything at once, no kill pulse
        step(); issue(2'b01, 5'd11);
        step(); ifc.id_valid = 1'b0; #1;
        check("rmul_busy_pre", 32'(busy),         32'd1);
        #2; reset = 1'b0; #1;
        check("rmul_busy",     32'(busy),         32'd0);
        check("rmul_kill",     32'(unit_kill),    32'd0);
        check("rmul_exv",      32'(ifc.ex_valid), 32'd0);
        check("rmul_tag",      32'(ifc.ex_tag),   32'd0);
        check("rmul_stall",    32'(stall_count),  32'd0);
        check("rmul_rdy",      32'(ifc.id_ready), 32'd0);
        step(); step(); #1;
        check("rmul_exv_hold", 32'(ifc.ex_valid), 32'd0);
        reset = 1'b1;
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/execute_issue_controller.md
Name: execute_issue_controller

Overview:
- Sequences the execute stage between decode and memory.
- Accepts one decoded instruction at a time over a valid/ready handshake and classifies it as ALU (single-cycle), MUL (fixed latency) or DIV (iterative, done-driven).
- Starts the matching unit, holds the result slot until the memory stage accepts it, and pulses execute_done on handoff.
- Supports pipeline flush and counts back-pressure stall cycles.

Parameters:
- MUL_LAT, 3: MUL cycles from accept to result valid; legal range 2..15.
- TAG_W, 5: width of the instruction tag carried through the stage.
- STALL_W, 16: width of the saturating stall counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode presents an instruction.
- id_ready  out  1  controller accepts this cycle.
- id_op_class  in  2  00 ALU, 01 MUL, 10 DIV, 11 NOP (treated as ALU).
- id_tag  in  TAG_W  instruction tag.
- flush  in  1  kill in-flight work (branch redirect).
- alu_en  out  1  one-cycle ALU enable.
- mul_start  out  1  one-cycle multiplier start.
- div_start  out  1  one-cycle divider start.
- div_done  in  1  divider result ready (one-cycle pulse).
- unit_kill  out  1  one-cycle abort to MUL/DIV units.
- ex_valid  out  1  result slot valid toward memory stage.
- ex_ready  in  1  memory stage accepts.
- ex_tag  out  TAG_W  tag of the held result.
- execute_done  out  1  pulse when ex_valid && ex_ready.
- busy  out  1  state != IDLE.
- stall_count  out  STALL_W  cycles with ex_valid && !ex_ready.

Behaviour:
- Reset (reset low, asynchronous):
  - State = IDLE.
  - All outputs 0, including ex_tag and stall_count.
  - id_ready is 0 while reset is asserted and IDLE-driven after release.
- States: IDLE, ALU_EX, MUL_WAIT, DIV_WAIT, HOLD.
- Accept condition: accept = id_valid && id_ready && !flush.
- id_ready is combinational: id_ready = !flush && (state==IDLE || (state==HOLD && ex_ready)).
- On accept:
  - Latch id_tag into ex_tag.
  - ALU/NOP: alu_en=1 this cycle, next state ALU_EX.
  - MUL: mul_start=1, load counter with MUL_LAT-1, next state MUL_WAIT.
  - DIV: div_start=1, next state DIV_WAIT.
- ALU_EX: next cycle goes to HOLD (ex_valid=1). Accept at cycle N gives ex_valid at N+2 (registered result).
- MUL_WAIT:
  - Counter decrements each cycle.
  - When counter==1, go to HOLD.
  - Accept at N gives ex_valid at N+MUL_LAT.
- DIV_WAIT:
  - Stays until div_done==1, then goes to HOLD next cycle.
  - No timeout.
  - A div_done in any other state is ignored.
- HOLD:
  - ex_valid=1, and ex_tag stays stable until handoff.
  - If ex_ready=1: execute_done=1. If an accept happens the same cycle, go directly to that op's state (back-to-back); otherwise go to IDLE.
  - If ex_ready=0: stay in HOLD and increment stall_count.
- stall_count saturates at 2^STALL_W-1 and is cleared only by reset.
- Flush (highest priority, any state):
  - Next state IDLE and ex_valid deasserted next cycle.
  - No accept that cycle.
  - unit_kill=1 for one cycle if state is MUL_WAIT or DIV_WAIT.
  - execute_done is suppressed that cycle even if ex_ready=1.
- Exclusivity: at most one of alu_en/mul_start/div_start is high in any cycle. Unit starts never fire on a flush cycle.
- Reset mid-operation: immediate return to IDLE with no unit_kill pulse (units reset themselves).

Test Plan:
- ALU: reset release; id_valid=1, op=00, tag=5 at cycle 0, ex_ready=1 -> alu_en at c0; ex_valid and execute_done at c2 with ex_tag=5; busy=0 at c3.
- MUL: op=01, tag=9 accepted at c0, MUL_LAT=3 -> mul_start at c0, ex_valid at c3, id_ready=0 during c1-c2.
- DIV with back-pressure: op=10 accepted at c0, div_done at c7 -> ex_valid at c8. Hold ex_ready=0 for 4 cycles -> stall_count=4 and ex_tag unchanged; execute_done on the cycle ex_ready rises.
- Back-to-back: in HOLD with ex_ready=1 and a new ALU op valid -> execute_done and alu_en in the same cycle; new tag on ex_tag two cycles later, with no IDLE gap.
- Flush: flush at c2 of DIV_WAIT -> unit_kill pulse at c2, state IDLE at c3, later div_done ignored. Flush with id_valid high -> id_ready=0 and no start pulse.
- Saturation and reset: force STALL_W=4, stall 20 cycles -> stall_count=15. Assert reset mid-MUL -> all outputs 0 immediately, no unit_kill.
